// File: rtl/loopback_pkg.sv
// rtl/loopback_pkg.sv - shared state type and PRBS7 helper for the loopback pattern checker
package loopback_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;   // x^7 term
  localparam int         PRBS7_TAP_B = 5;   // x^6 term
  localparam int         HIST_W      = 32;

  // History of produced bits, newest in bit 0, so the low 7 bits are the next LFSR state
  // and the low nbits form a word with the earliest bit in the MSB.
  function automatic logic [HIST_W-1:0] prbs7_step(input logic [6:0] seed, input int nbits);
    logic [HIST_W-1:0] hist;
    hist = {{(HIST_W-7){1'b0}}, seed};
    for (int i = 0; i < nbits; i++) begin
      hist = {hist[HIST_W-2:0], hist[PRBS7_TAP_A] ^ hist[PRBS7_TAP_B]};
    end
    return hist;
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - TX word generator, incrementing counter or PRBS7
module pattern_gen
  import loopback_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] tx_data
);

  logic [6:0]        lfsr;
  logic [DATA_W-1:0] prbs_word;

  always_comb begin
    prbs_word = DATA_W'(prbs7_step(lfsr, DATA_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= '0;
      lfsr    <= PRBS7_SEED;
    end else if (en) begin
      if (MODE == 1) begin
        tx_data <= prbs_word;
        lfsr    <= prbs_word[6:0];
      end else begin
        tx_data <= tx_data + DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/loopback_pattern_checker.sv
// rtl/loopback_pattern_checker.sv - loopback pattern source plus word-aligning checker
module loopback_pattern_checker
  import loopback_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MODE       = 0,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_valid,
  input  logic                      clear_cnt,
  output logic                      locked,
  output logic [$clog2(DATA_W)-1:0] slip,
  output logic [1:0]                state,
  output logic                      err_pulse,
  output logic [CNT_W-1:0]          word_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int SW = $clog2(DATA_W);

  state_t            st;
  logic [DATA_W-1:0] prev_rx;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] pred_next;
  logic              match;
  logic [7:0]        match_run;
  logic [7:0]        err_run;
  logic              settle_cnt;

  pattern_gen #(.DATA_W(DATA_W), .MODE(MODE)) u_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .tx_data (tx_data)
  );

  assign state = st;

  // expected always holds the prediction made from the previous aligned word
  always_comb begin
    aligned = DATA_W'(({prev_rx, rx_data} << slip) >> DATA_W);
    if (MODE == 1) pred_next = DATA_W'(prbs7_step(aligned[6:0], DATA_W));
    else           pred_next = aligned + DATA_W'(1);
    match = (aligned == expected);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= SETTLE;
      prev_rx    <= '0;
      expected   <= '0;
      slip       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      word_cnt   <= '0;
      err_cnt    <= '0;
      match_run  <= '0;
      err_run    <= '0;
      settle_cnt <= 1'b0;
    end else begin
      err_pulse <= 1'b0;

      if (clear_cnt) begin
        word_cnt <= '0;
        err_cnt  <= '0;
      end else if (rx_valid && st == LOCKED) begin
        if (!(&word_cnt))         word_cnt <= word_cnt + CNT_W'(1);
        if (!match && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
      end

      if (rx_valid) begin
        prev_rx  <= rx_data;
        expected <= pred_next;
        unique case (st)
          SETTLE: begin
            settle_cnt <= ~settle_cnt;
            if (settle_cnt) begin
              st        <= SEARCH;
              match_run <= '0;
            end
          end
          SEARCH: begin
            if (match) begin
              if (match_run == 8'(LOCK_CNT - 1)) begin
                st      <= LOCKED;
                locked  <= 1'b1;
                err_run <= '0;
              end else begin
                match_run <= match_run + 8'd1;
              end
            end else begin
              slip <= (slip == SW'(DATA_W - 1)) ? '0 : slip + SW'(1);
              st   <= SETTLE;
            end
          end
          LOCKED: begin
            if (match) begin
              err_run <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (err_run == 8'(UNLOCK_ERR - 1)) begin
                st        <= SEARCH;
                locked    <= 1'b0;
                match_run <= '0;
                err_run   <= '0;
              end else begin
                err_run <= err_run + 8'd1;
              end
            end
          end
          default: st <= SETTLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loopback_pattern_checker.sv
// tb/tb_loopback_pattern_checker.sv - directed bench for loopback_pattern_checker
`timescale 1ns/1ps
module tb_loopback_pattern_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, rx_valid_a, clear_a;
  logic [7:0]  rx_data_a, tx_a;
  logic        locked_a, err_pulse_a;
  logic [2:0]  slip_a;
  logic [1:0]  state_a;
  logic [31:0] word_cnt_a, err_cnt_a;

  logic        rst_b, en_b, rx_valid_b, clear_b;
  logic [15:0] rx_data_b, tx_b;
  logic        locked_b, err_pulse_b;
  logic [3:0]  slip_b;
  logic [1:0]  state_b;
  logic [3:0]  word_cnt_b, err_cnt_b;

  loopback_pattern_checker #(.DATA_W(8), .MODE(0), .LOCK_CNT(16), .UNLOCK_ERR(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .tx_data(tx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .clear_cnt(clear_a), .locked(locked_a), .slip(slip_a), .state(state_a), .err_pulse(err_pulse_a),
    .word_cnt(word_cnt_a), .err_cnt(err_cnt_a)
  );

  loopback_pattern_checker #(.DATA_W(16), .MODE(1), .LOCK_CNT(16), .UNLOCK_ERR(255), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .tx_data(tx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .clear_cnt(clear_b), .locked(locked_b), .slip(slip_b), .state(state_b), .err_pulse(err_pulse_b),
    .word_cnt(word_cnt_b), .err_cnt(err_cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A-side loopback: 3-cycle delay of tx_a, then a bit rotation of 'rot' bits
  logic [7:0] d1, d2, d3, prev_t;
  int n_push, seen, rot, pulses, guard;

  task automatic a_reset(input int r);
    rst_a = 1'b1; en_a = 1'b1; rx_valid_a = 1'b0; rx_data_a = '0; clear_a = 1'b0;
    d1 = '0; d2 = '0; d3 = '0; prev_t = '0; n_push = 0; seen = 0; rot = r;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  task automatic a_cycle(input logic flip, input logic clr);
    logic [7:0]  t;
    logic [15:0] pair;
    @(posedge clk); #1;
    if (rx_valid_a) seen++;
    d3 = d2; d2 = d1; d1 = tx_a; n_push++;
    t = d3;
    if (flip) t[0] = ~t[0];
    pair = {prev_t, t} >> rot;
    rx_data_a  = pair[7:0];
    rx_valid_a = (n_push >= 3);
    clear_a    = clr;
    prev_t     = t;
  endtask

  task automatic b_cycle(input logic flip);
    @(posedge clk); #1;
    rx_data_b  = tx_b ^ {15'd0, flip};
    rx_valid_b = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b1; en_b = 1'b0; rx_valid_b = 1'b0; rx_data_b = '0; clear_b = 1'b0;

    // reset state and counter-mode lock with straight alignment
    a_reset(0);
    check("rst_tx", tx_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_state", state_a, 0);
    check("rst_slip", slip_a, 0);
    check("rst_err_pulse", err_pulse_a, 0);
    check("rst_word_cnt", word_cnt_a, 0);
    check("rst_err_cnt", err_cnt_a, 0);
    guard = 0;
    while (seen < 17 && guard < 100) begin
      a_cycle(1'b0, 1'b0);
      guard++;
      if (n_push <= 4) check("tx_count", tx_a, 32'(n_push));
    end
    check("lock_at_17", locked_a, 0);
    check("state_search", state_a, 1);
    a_cycle(1'b0, 1'b0);
    check("lock_at_18", locked_a, 1);
    check("state_locked", state_a, 2);
    check("slip0", slip_a, 0);
    check("err_after_lock", err_cnt_a, 0);
    check("word_at_lock", word_cnt_a, 0);
    while (n_push < 260) a_cycle(1'b0, 1'b0);
    check("tx_wrap", tx_a, 32'(n_push % 256));
    check("locked_wrap", locked_a, 1);
    check("err_wrap", err_cnt_a, 0);
    check("word_cnt_wrap", word_cnt_a, 32'(seen - 18));

    // stream late by 3 bits: slip search must settle on 3
    a_reset(3);
    guard = 0;
    while (!locked_a && guard < 300) begin a_cycle(1'b0, 1'b0); guard++; end
    check("lock_rot3", locked_a, 1);
    check("slip3", slip_a, 3);
    repeat (40) a_cycle(1'b0, 1'b0);
    check("rot3_err", err_cnt_a, 0);
    check("rot3_words", word_cnt_a, 40);

    // one corrupted word breaks two predictions
    a_cycle(1'b1, 1'b0);
    pulses = 0;
    repeat (6) begin a_cycle(1'b0, 1'b0); pulses += int'(err_pulse_a); end
    check("single_err_cnt", err_cnt_a, 2);
    check("single_pulses", pulses, 2);
    check("single_locked", locked_a, 1);

    // four corrupted words drop lock; relock at the same slip after a full slip cycle
    repeat (4) a_cycle(1'b1, 1'b0);
    a_cycle(1'b0, 1'b0);
    check("locked_after_3", locked_a, 1);
    a_cycle(1'b0, 1'b0);
    check("unlock_state", state_a, 1);
    check("unlock_locked", locked_a, 0);
    check("unlock_err_cnt", err_cnt_a, 6);
    check("unlock_slip", slip_a, 3);
    guard = 0;
    while (!locked_a && guard < 400) begin a_cycle(1'b0, 1'b0); guard++; end
    check("relock", locked_a, 1);
    check("relock_slip", slip_a, 3);
    check("frozen_err_cnt", err_cnt_a, 6);

    // clear_cnt on the same edge as an error wins
    a_cycle(1'b1, 1'b0);
    a_cycle(1'b0, 1'b0);
    a_cycle(1'b0, 1'b1);
    check("err_before_clear", err_cnt_a, 7);
    a_cycle(1'b0, 1'b0);
    check("clear_err_cnt", err_cnt_a, 0);
    check("clear_word_cnt", word_cnt_a, 0);

    // build err_cnt=5 while locked, then async reset
    a_cycle(1'b1, 1'b0);
    repeat (4) a_cycle(1'b0, 1'b0);
    a_cycle(1'b1, 1'b0);
    a_cycle(1'b1, 1'b0);
    repeat (4) a_cycle(1'b0, 1'b0);
    check("err_cnt_5", err_cnt_a, 5);
    check("locked_5", locked_a, 1);
    #2 rst_a = 1'b1;
    #1;
    check("async_tx", tx_a, 0);
    check("async_locked", locked_a, 0);
    check("async_state", state_a, 0);
    check("async_slip", slip_a, 0);
    check("async_err_pulse", err_pulse_a, 0);
    check("async_word_cnt", word_cnt_a, 0);
    check("async_err_cnt", err_cnt_a, 0);

    // PRBS7, 16-bit words, 4-bit saturating counters
    en_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    check("b_rst_tx", tx_b, 0);
    b_cycle(1'b0);
    check("prbs_w1", tx_b, 32'h020C);
    b_cycle(1'b0);
    check("prbs_w2", tx_b, 32'h28F2);
    guard = 0;
    while (!locked_b && guard < 100) begin b_cycle(1'b0); guard++; end
    check("b_lock", locked_b, 1);
    check("b_slip", slip_b, 0);
    check("b_err_clean", err_cnt_b, 0);
    repeat (25) b_cycle(1'b1);
    check("b_err_sat", err_cnt_b, 15);
    check("b_word_sat", word_cnt_b, 15);
    check("b_still_locked", locked_b, 1);
    check("b_state", state_b, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
